// File: rtl/crypto_csr_interface.sv
// Register front-end for hash/cipher cores: block/digest/ctrl/status CSRs
// behind a valid/ready request bus with a registered, backpressured response.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   req*_i / reqready_o     request channel (addr, data, write, strobe)
//   rsp*_o / rspready_i     response channel (data, error)
//   block_o                 message block to core, register 0 in the LSBs
//   start_o / busy_o        one-cycle start pulse and core-running flag
//   core_done_i, digest_i   completion pulse and result from the core
module crypto_csr_interface #(
  parameter int DataWidth   = 64,
  parameter int AddrWidth   = 32,
  parameter int DataBytes   = DataWidth / 8,
  parameter int BlockWidth  = 512,
  parameter int DigestWidth = 160
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [DataWidth-1:0]   reqdata_i,
  input  logic [AddrWidth-1:0]   reqaddr_i,
  input  logic                   reqvalid_i,
  input  logic                   reqwrite_i,
  input  logic [DataBytes-1:0]   reqstrobe_i,
  output logic                   reqready_o,
  output logic                   rspvalid_o,
  input  logic                   rspready_i,
  output logic [DataWidth-1:0]   rspdata_o,
  output logic                   rsperror_o,
  output logic [BlockWidth-1:0]  block_o,
  output logic                   start_o,
  input  logic                   core_done_i,
  input  logic [DigestWidth-1:0] digest_i,
  output logic                   busy_o
);

  localparam int NB       = BlockWidth / DataWidth;
  localparam int ND       = (DigestWidth + DataWidth - 1) / DataWidth;
  localparam int OffBits  = $clog2(DataBytes);
  localparam int IdxW     = $clog2(NB + ND + 2);
  localparam int AddrBits = OffBits + IdxW;

  localparam logic [IdxW-1:0] IdxNb   = IdxW'(NB);
  localparam logic [IdxW-1:0] IdxCtrl = IdxW'(NB + ND);
  localparam logic [IdxW-1:0] IdxStat = IdxW'(NB + ND + 1);

  typedef enum logic {
    B_IDLE,
    B_RESP
  } bus_e;

  typedef enum logic {
    C_IDLE,
    C_BUSY
  } core_e;

  bus_e                 bus_q, bus_d;
  core_e                core_q, core_d;
  logic [DataWidth-1:0] blk_q [NB];
  logic [DataWidth-1:0] blk_d [NB];
  logic [DataWidth-1:0] dig_q [ND];
  logic [DataWidth-1:0] dig_d [ND];
  logic                 done_q, done_d;
  logic                 start_q, start_d;
  logic [DataWidth-1:0] rdata_q, rdata_d;
  logic                 rerr_q, rerr_d;

  logic [IdxW-1:0]         idx;
  logic                    misal;
  logic                    legal;
  logic                    is_blk;
  logic                    is_dig;
  logic                    busy;
  logic [ND*DataWidth-1:0] dig_pad;
  logic                    unused_addr;

  assign idx         = reqaddr_i[AddrBits-1:OffBits];
  assign misal       = |reqaddr_i[OffBits-1:0];
  assign unused_addr = ^reqaddr_i[AddrWidth-1:AddrBits];
  assign legal       = !misal && (idx <= IdxStat);
  assign is_blk      = idx < IdxNb;
  assign is_dig      = (idx >= IdxNb) && (idx < IdxCtrl);
  assign busy        = core_q == C_BUSY;

  always_comb begin
    bus_d   = bus_q;
    core_d  = core_q;
    blk_d   = blk_q;
    dig_d   = dig_q;
    done_d  = done_q;
    start_d = 1'b0;
    rdata_d = rdata_q;
    rerr_d  = rerr_q;
    dig_pad = '0;
    dig_pad[DigestWidth-1:0] = digest_i;

    unique case (bus_q)
      B_IDLE: begin
        if (reqvalid_i) begin
          bus_d   = B_RESP;
          rdata_d = '0;
          rerr_d  = 1'b0;
          if (!legal) begin
            rerr_d = 1'b1;
          end else if (!reqwrite_i) begin
            for (int i = 0; i < NB; i++)
              if (idx == IdxW'(i)) rdata_d = blk_q[i];
            for (int i = 0; i < ND; i++)
              if (idx == IdxW'(NB + i)) rdata_d = dig_q[i];
            if (idx == IdxStat) rdata_d[1:0] = {done_q, busy};
          end else if (is_blk) begin
            if (busy) begin
              rerr_d = 1'b1;
            end else begin
              for (int i = 0; i < NB; i++)
                for (int b = 0; b < DataBytes; b++)
                  if (idx == IdxW'(i) && reqstrobe_i[b])
                    blk_d[i][b*8 +: 8] = reqdata_i[b*8 +: 8];
            end
          end else if (is_dig) begin
            rerr_d = 1'b1;
          end else if (idx == IdxCtrl) begin
            if (reqstrobe_i[0]) begin
              if (busy && (reqdata_i[0] || reqdata_i[1])) begin
                rerr_d = 1'b1;
              end else begin
                // CLEAR ahead of START so both together give a clean run
                if (reqdata_i[1]) begin
                  for (int i = 0; i < NB; i++) blk_d[i] = '0;
                  for (int i = 0; i < ND; i++) dig_d[i] = '0;
                  done_d = 1'b0;
                end
                if (reqdata_i[0]) begin
                  start_d = 1'b1;
                  core_d  = C_BUSY;
                  done_d  = 1'b0;
                end
              end
            end
          end else begin
            if (reqstrobe_i[0] && reqdata_i[1]) done_d = 1'b0;
          end
        end
      end
      B_RESP: begin
        if (rspready_i) bus_d = B_IDLE;
      end
      default: bus_d = B_IDLE;
    endcase

    // Completion last: a same-cycle done W1C loses to the new done
    if (busy && core_done_i) begin
      for (int i = 0; i < ND; i++)
        dig_d[i] = dig_pad[i*DataWidth +: DataWidth];
      done_d = 1'b1;
      core_d = C_IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus_q   <= B_IDLE;
      core_q  <= C_IDLE;
      for (int i = 0; i < NB; i++) blk_q[i] <= '0;
      for (int i = 0; i < ND; i++) dig_q[i] <= '0;
      done_q  <= 1'b0;
      start_q <= 1'b0;
      rdata_q <= '0;
      rerr_q  <= 1'b0;
    end else begin
      bus_q   <= bus_d;
      core_q  <= core_d;
      blk_q   <= blk_d;
      dig_q   <= dig_d;
      done_q  <= done_d;
      start_q <= start_d;
      rdata_q <= rdata_d;
      rerr_q  <= rerr_d;
    end
  end

  always_comb begin
    block_o = '0;
    for (int i = 0; i < NB; i++)
      block_o[i*DataWidth +: DataWidth] = blk_q[i];
  end

  assign reqready_o = bus_q == B_IDLE;
  assign rspvalid_o = bus_q == B_RESP;
  assign rspdata_o  = rdata_q;
  assign rsperror_o = rerr_q;
  assign start_o    = start_q;
  assign busy_o     = busy;

endmodule

// File: tb/tb_crypto_csr_interface.sv
// Scoreboard bench for crypto_csr_interface: reference CSR model,
// directed scenarios, then randomized bus traffic and core completions.
module tb_crypto_csr_interface;

  logic         clk = 1'b0;
  logic         rst_i;
  logic [63:0]  reqdata_i;
  logic [31:0]  reqaddr_i;
  logic         reqvalid_i;
  logic         reqwrite_i;
  logic [7:0]   reqstrobe_i;
  logic         reqready_o;
  logic         rspvalid_o;
  logic         rspready_i;
  logic [63:0]  rspdata_o;
  logic         rsperror_o;
  logic [511:0] block_o;
  logic         start_o;
  logic         core_done_i;
  logic [159:0] digest_i;
  logic         busy_o;

  crypto_csr_interface dut (
    .clk_i(clk), .rst_i(rst_i),
    .reqdata_i(reqdata_i), .reqaddr_i(reqaddr_i),
    .reqvalid_i(reqvalid_i), .reqwrite_i(reqwrite_i),
    .reqstrobe_i(reqstrobe_i), .reqready_o(reqready_o),
    .rspvalid_o(rspvalid_o), .rspready_i(rspready_i),
    .rspdata_o(rspdata_o), .rsperror_o(rsperror_o),
    .block_o(block_o), .start_o(start_o),
    .core_done_i(core_done_i), .digest_i(digest_i),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [63:0] data;
    logic        err;
  } rsp_t;
  rsp_t sb[$];

  // reference model state
  logic [63:0] m_blk [8];
  logic [63:0] m_dig [3];
  logic        m_done;
  logic        m_busy;

  // 0 random, 1 held low, 2 held high
  int rdy_mode = 0;

  always @(posedge clk) begin
    #2;
    rspready_i = (rdy_mode == 1) ? 1'b0 :
                 (rdy_mode == 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
  end

  task automatic check(input string name, input logic [511:0] act,
                       input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_i && rspvalid_o && rspready_i) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rsp_unexpected: got %0h expected none", rspdata_o);
      end else begin
        rsp_t e;
        e = sb.pop_front();
        check("rsp_data", 512'(rspdata_o), 512'(e.data));
        check("rsp_err", 512'(rsperror_o), 512'(e.err));
      end
    end
  end

  function automatic logic [511:0] m_block();
    logic [511:0] v;
    for (int i = 0; i < 8; i++) v[i*64 +: 64] = m_blk[i];
    return v;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 8; i++) m_blk[i] = '0;
    for (int i = 0; i < 3; i++) m_dig[i] = '0;
    m_done = 1'b0;
    m_busy = 1'b0;
  endtask

  task automatic m_core_done(input bit was_busy, input logic [159:0] dg);
    logic [191:0] t;
    if (was_busy) begin
      t = {32'b0, dg};
      for (int i = 0; i < 3; i++) m_dig[i] = t[i*64 +: 64];
      m_done = 1'b1;
      m_busy = 1'b0;
    end
  endtask

  // Applies one access to the model, pushes the expected response.
  task automatic m_access(input bit wr, input logic [31:0] addr,
                          input logic [63:0] data, input logic [7:0] strb,
                          input bit pulse, input logic [159:0] dg,
                          output bit exp_start);
    rsp_t r;
    int   idx;
    bit   pre_busy;
    pre_busy  = m_busy;
    exp_start = 0;
    r.data    = '0;
    r.err     = 1'b0;
    idx       = int'(addr[6:3]);
    if (addr[2:0] != 0 || idx > 12) begin
      r.err = 1'b1;
    end else if (!wr) begin
      if (idx < 8) r.data = m_blk[idx];
      else if (idx < 11) r.data = m_dig[idx-8];
      else if (idx == 12) r.data = {62'b0, m_done, m_busy};
    end else if (idx < 8) begin
      if (pre_busy) r.err = 1'b1;
      else
        for (int b = 0; b < 8; b++)
          if (strb[b]) m_blk[idx][b*8 +: 8] = data[b*8 +: 8];
    end else if (idx < 11) begin
      r.err = 1'b1;
    end else if (idx == 11) begin
      if (strb[0]) begin
        if (pre_busy && (data[0] || data[1])) r.err = 1'b1;
        else begin
          if (data[1]) begin
            for (int i = 0; i < 8; i++) m_blk[i] = '0;
            for (int i = 0; i < 3; i++) m_dig[i] = '0;
            m_done = 1'b0;
          end
          if (data[0]) begin
            m_busy    = 1'b1;
            m_done    = 1'b0;
            exp_start = 1;
          end
        end
      end
    end else begin
      if (strb[0] && data[1]) m_done = 1'b0;
    end
    if (pulse) m_core_done(pre_busy, dg);
    sb.push_back(r);
  endtask

  task automatic issue(input bit wr, input logic [31:0] addr,
                       input logic [63:0] data, input logic [7:0] strb,
                       input bit pulse, input logic [159:0] dg);
    bit es;
    @(posedge clk); #1;
    reqvalid_i  = 1'b1;
    reqwrite_i  = wr;
    reqaddr_i   = addr;
    reqdata_i   = data;
    reqstrobe_i = strb;
    core_done_i = pulse;
    digest_i    = dg;
    m_access(wr, addr, data, strb, pulse, dg, es);
    @(posedge clk); #1;
    reqvalid_i  = 1'b0;
    core_done_i = 1'b0;
    check("start_pulse", 512'(start_o), 512'(es));
    check("busy", 512'(busy_o), 512'(m_busy));
    check("block_o", block_o, m_block());
    if (es) begin
      @(posedge clk); #1;
      check("start_one_cycle", 512'(start_o), 512'(0));
    end
  endtask

  task automatic drain();
    bit ok = 0;
    for (int c = 0; c < 60 && !ok; c++) begin
      @(posedge clk); #1;
      if (sb.size() == 0 && reqready_o) ok = 1;
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic req(input bit wr, input logic [31:0] addr,
                     input logic [63:0] data, input logic [7:0] strb,
                     input bit pulse, input logic [159:0] dg);
    issue(wr, addr, data, strb, pulse, dg);
    drain();
  endtask

  task automatic pulse_done(input logic [159:0] dg);
    bit pb;
    @(posedge clk); #1;
    pb          = m_busy;
    core_done_i = 1'b1;
    digest_i    = dg;
    m_core_done(pb, dg);
    @(posedge clk); #1;
    core_done_i = 1'b0;
    check("busy_after_done", 512'(busy_o), 512'(m_busy));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_i = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    m_reset();
    sb.delete();
  endtask

  localparam logic [31:0] A_CTRL = 32'd11 << 3;
  localparam logic [31:0] A_STAT = 32'd12 << 3;
  localparam logic [159:0] DG_A5 = {20{8'hA5}};

  initial begin
    logic [63:0] held;
    rst_i       = 1'b1;
    reqvalid_i  = 1'b0;
    reqwrite_i  = 1'b0;
    reqaddr_i   = '0;
    reqdata_i   = '0;
    reqstrobe_i = '0;
    core_done_i = 1'b0;
    digest_i    = '0;
    rspready_i  = 1'b1;
    m_reset();
    do_reset();

    check("rst_reqready", 512'(reqready_o), 512'(1));
    check("rst_rspvalid", 512'(rspvalid_o), 512'(0));
    check("rst_rspdata", 512'(rspdata_o), 512'(0));
    check("rst_rsperror", 512'(rsperror_o), 512'(0));
    check("rst_busy", 512'(busy_o), 512'(0));
    check("rst_start", 512'(start_o), 512'(0));
    check("rst_block", block_o, 512'(0));

    req(0, A_STAT, 0, 8'hFF, 0, 0);
    req(1, 0, 64'h0123456789ABCDEF, 8'h0F, 0, 0);
    check("block_lo", 512'(block_o[63:0]), 512'(64'h0000000089ABCDEF));
    req(0, 0, 0, 8'hFF, 0, 0);

    // backpressure: response must hold while ready is low
    rdy_mode = 1;
    @(posedge clk); #1;
    issue(0, 0, 0, 8'hFF, 0, 0);
    held = rspdata_o;
    check("bp_held_value", 512'(held), 512'(64'h0000000089ABCDEF));
    for (int c = 0; c < 5; c++) begin
      check("bp_valid", 512'(rspvalid_o), 512'(1));
      check("bp_reqready", 512'(reqready_o), 512'(0));
      check("bp_stable", 512'(rspdata_o), 512'(held));
      @(posedge clk); #1;
    end
    rdy_mode = 2;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("bp_released", 512'(rspvalid_o), 512'(0));
    rdy_mode = 0;
    drain();

    // run, write-lock, completion
    req(1, A_CTRL, 64'h1, 8'h01, 0, 0);
    req(1, 3 << 3, 64'hFFFF, 8'hFF, 0, 0);
    req(0, 3 << 3, 0, 8'hFF, 0, 0);
    req(1, A_CTRL, 64'h1, 8'h01, 0, 0);
    pulse_done(DG_A5);
    req(0, A_STAT, 0, 8'hFF, 0, 0);
    for (int i = 0; i < 3; i++) req(0, (8 + i) << 3, 0, 8'hFF, 0, 0);

    // new run; W1C and completion in the same cycle
    req(1, A_CTRL, 64'h1, 8'h01, 0, 0);
    req(0, 8 << 3, 0, 8'hFF, 1, {5{32'h1234_5678}});
    req(1, A_CTRL, 64'h1, 8'h01, 0, 0);
    req(1, A_STAT, 64'h2, 8'h01, 1, {5{32'hCAFE_F00D}});
    req(0, A_STAT, 0, 8'hFF, 0, 0);
    req(1, A_STAT, 64'h2, 8'h01, 0, 0);
    req(0, A_STAT, 0, 8'hFF, 0, 0);

    // illegal accesses and reset mid-run
    req(1, 32'h3, 64'h1, 8'hFF, 0, 0);
    req(1, 9 << 3, 64'h1, 8'hFF, 0, 0);
    req(1, 5 << 3, 64'h77, 8'h00, 0, 0);
    req(1, A_CTRL, 64'h1, 8'h01, 0, 0);
    do_reset();
    check("rst_mid_busy", 512'(busy_o), 512'(0));
    check("rst_mid_block", block_o, 512'(0));
    pulse_done(DG_A5);
    req(0, 8 << 3, 0, 8'hFF, 0, 0);

    for (int n = 0; n < 300; n++) begin
      logic [31:0]  a;
      logic [63:0]  d;
      logic [159:0] g;
      int           op;
      op = $urandom_range(0, 9);
      d  = {$urandom, $urandom};
      g  = {$urandom, $urandom, $urandom, $urandom, $urandom};
      a  = 32'($urandom) & 32'hFFFF_FF80;
      unique case (op)
        0, 1, 2, 3: a = a | ($urandom_range(0, 7) << 3);
        4:          a = a | ($urandom_range(8, 10) << 3);
        5: begin
          a = a | A_CTRL;
          d = 64'($urandom_range(0, 3));
        end
        6: begin
          a = a | A_STAT;
          d = 64'($urandom_range(0, 3) << 1);
        end
        7: a = a | (($urandom_range(0, 1) != 0) ?
                    ($urandom_range(13, 15) << 3) :
                    ($urandom_range(0, 12) << 3) | $urandom_range(1, 7));
        default: a = a | ($urandom_range(0, 12) << 3);
      endcase
      if (op == 8) pulse_done(g);
      else
        req($urandom_range(0, 1) != 0, a, d, 8'($urandom),
            (op == 9) || ($urandom_range(0, 7) == 0), g);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
